ccff_bitstream_loader: RTL

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

---
 rtl/ccff_bitstream_loader.sv | 91 +++++++++
 1 files changed

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: streams bitstream words LSB-first into a configuration chain.
// Define CCFF_READBACK_CHECK_EN to add a shadow register and a readback verify pass.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(CHAIN_LEN);
  localparam int BW = $clog2(WORD_W);
`ifdef CCFF_READBACK_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, VERIFY, DONE} state_t;
  localparam state_t AFTER_SHIFT = VERIFY;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam state_t AFTER_SHIFT = DONE;
`endif
  state_t state, state_nxt;
  logic [WORD_W-1:0] word;
  logic word_full;
  logic [BW-1:0] bit_idx;
  logic [CW-1:0] bit_cnt;
  logic shifting, verifying, last, shadow_bit;
`ifdef CCFF_READBACK_CHECK_EN
  logic [CHAIN_LEN-1:0] shadow;
  assign verifying = state == VERIFY;
  assign shadow_bit = shadow[bit_cnt[IW-1:0]];
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign verifying = 1'b0;
  assign shadow_bit = 1'b0;
  assign error = 1'b0;
`endif
  assign shifting = state == SHIFT && word_full;
  assign last = bit_cnt == CW'(CHAIN_LEN - 1);
  assign bs_ready = state == SHIFT && !word_full && bit_cnt < CW'(CHAIN_LEN);
  assign ccff_clk_en = shifting || verifying;
  assign ccff_head = shifting ? word[bit_idx] : verifying && shadow_bit;
  always_comb
    state_nxt = (state == IDLE && start) ? SHIFT :
                (shifting && last)       ? AFTER_SHIFT :
                (verifying && last)      ? DONE :
                (state == DONE)          ? IDLE : state;
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      word <= '0;
      word_full <= 1'b0;
      bit_idx <= '0;
      bit_cnt <= '0;
`ifdef CCFF_READBACK_CHECK_EN
      shadow <= '0;
      error <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      busy <= state_nxt != IDLE && state_nxt != DONE;
      done <= state_nxt == DONE;
      if (bs_valid && bs_ready) begin
        word <= bs_data;
        word_full <= 1'b1;
        bit_idx <= '0;
      end
      // The final chain bit also drops any unshifted tail of the current word.
      if (shifting) begin
        bit_idx <= bit_idx + BW'(1);
        if (last || bit_idx == BW'(WORD_W - 1)) word_full <= 1'b0;
      end
      if (ccff_clk_en) bit_cnt <= last ? '0 : bit_cnt + CW'(1);
`ifdef CCFF_READBACK_CHECK_EN
      if (shifting) shadow[bit_cnt[IW-1:0]] <= word[bit_idx];
      if (state == IDLE && start) error <= 1'b0;
      else if (verifying && ccff_tail != shadow_bit) error <= 1'b1;
`endif
    end
endmodule
